// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI field widths, encodings, data-master FSM states and
// the single-beat write strobe helper.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package axi_pkg;
    typedef enum logic [2:0] {DM_IDLE, DM_AR, DM_R, DM_AW, DM_W, DM_B} dm_state_e;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    function automatic logic [3:0] gen_strb(input logic [1:0] size, input logic [1:0] addr_lo);
        return size == SIZE_BYTE ? 4'b0001 << addr_lo :
               size == SIZE_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/axi_dm_strb_gen.sv
// axi_dm_strb_gen: write strobe for a single beat; word stores keep the caller's strobe.
module axi_dm_strb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic [3:0] wr_strb,
    output logic [3:0] strb
);
    assign strb = size == SIZE_WORD ? wr_strb : gen_strb(size, addr_lo);
endmodule

// File: rtl/axi_burst_dmaster.sv
// axi_burst_dmaster: one-request-at-a-time INCR burst AXI master for the CPU data side.
module axi_burst_dmaster
    import axi_pkg::*;
#(
    parameter logic [`AXI_ID_BITS-1:0] ID = 4'd0,
    parameter int MAX_BEATS = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [7:0]                  req_len,
    input  logic [1:0]                  req_size,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [31:0]                 wr_data,
    input  logic [3:0]                  wr_strb,
    output logic                        rd_valid,
    output logic [31:0]                 rd_data,
    output logic                        rd_last,
    output logic                        done,
    output logic                        err,
    output logic [`AXI_ID_BITS-1:0]     ARID,
    output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
    output logic [`AXI_LEN_BITS-1:0]    ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    output logic [`AXI_BURST_BITS-1:0]  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [`AXI_ID_BITS-1:0]     RID,
    input  logic [`AXI_DATA_BITS-1:0]   RDATA,
    input  logic [`AXI_RESP_BITS-1:0]   RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,
    output logic [`AXI_ID_BITS-1:0]     AWID,
    output logic [`AXI_ADDR_BITS-1:0]   AWADDR,
    output logic [`AXI_LEN_BITS-1:0]    AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
    output logic [`AXI_BURST_BITS-1:0]  AWBURST,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [`AXI_DATA_BITS-1:0]   WDATA,
    output logic [`AXI_STRB_BITS-1:0]   WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,
    input  logic [`AXI_ID_BITS-1:0]     BID,
    input  logic [`AXI_RESP_BITS-1:0]   BRESP,
    input  logic                        BVALID,
    output logic                        BREADY
);
    localparam int CW = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
    dm_state_e     state;
    logic [31:0]   addr;
    logic [7:0]    len;
    logic [1:0]    size;
    logic [CW-1:0] cnt;
    logic          sticky, ill_q;
    logic          illegal, last, r_beat, b_done, beat_err, in_w;
    logic [3:0]    strb_gen;

    assign illegal  = int'(req_len) >= MAX_BEATS || (req_len != 8'd0 && req_size != SIZE_WORD) || req_size == 2'd3;
    assign last     = 8'(cnt) == len;
    assign r_beat   = state == DM_R && RVALID;
    assign b_done   = state == DM_B && BVALID;
    assign in_w     = state == DM_W;
    assign beat_err = RRESP != RESP_OKAY || RID != ID || RLAST != last;

    assign req_ready = state == DM_IDLE;
    assign done      = ill_q || (r_beat && last) || b_done;
    // An illegal request reports through the registered pulse; bus paths only while done.
    assign err       = ill_q || (r_beat && last && (sticky || beat_err)) ||
                       (b_done && (BRESP != RESP_OKAY || BID != ID));

    assign ARVALID = state == DM_AR;
    assign ARID    = ARVALID ? ID : '0;
    assign ARADDR  = ARVALID ? addr : '0;
    assign ARLEN   = ARVALID ? len : '0;
    assign ARSIZE  = ARVALID ? {1'b0, size} : '0;
    assign ARBURST = ARVALID ? BURST_INCR : '0;

    assign RREADY   = state == DM_R;
    assign rd_valid = r_beat;
    assign rd_data  = RREADY ? RDATA : '0;
    assign rd_last  = r_beat && last;

    assign AWVALID = state == DM_AW;
    assign AWID    = AWVALID ? ID : '0;
    assign AWADDR  = AWVALID ? addr : '0;
    assign AWLEN   = AWVALID ? len : '0;
    assign AWSIZE  = AWVALID ? {1'b0, size} : '0;
    assign AWBURST = AWVALID ? BURST_INCR : '0;

    assign WVALID   = in_w && wr_valid;
    assign wr_ready = in_w && WREADY;
    assign WDATA    = in_w ? wr_data : '0;
    assign WLAST    = in_w && last;
    assign WSTRB    = in_w ? (len == 8'd0 ? strb_gen : wr_strb) : '0;
    assign BREADY   = state == DM_B;

    axi_dm_strb_gen u_strb (
        .size    (size),
        .addr_lo (addr[1:0]),
        .wr_strb (wr_strb),
        .strb    (strb_gen)
    );

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            state  <= DM_IDLE;
            addr   <= '0;
            len    <= '0;
            size   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            ill_q <= req_ready && req_valid && illegal;
            case (state)
                DM_IDLE: if (req_valid) begin
                    addr   <= req_addr;
                    len    <= req_len;
                    size   <= req_size;
                    cnt    <= '0;
                    sticky <= 1'b0;
                    state  <= illegal ? DM_IDLE : req_write ? DM_AW : DM_AR;
                end
                DM_AR: if (ARREADY) state <= DM_R;
                DM_R: if (RVALID) begin
                    sticky <= sticky || beat_err;
                    if (last) state <= DM_IDLE;
                    else cnt <= cnt + CW'(1);
                end
                DM_AW: if (AWREADY) state <= DM_W;
                DM_W: if (wr_valid && WREADY) begin
                    if (last) state <= DM_B;
                    else cnt <= cnt + CW'(1);
                end
                DM_B: if (BVALID) state <= DM_IDLE;
                default: state <= DM_IDLE;
            endcase
        end
endmodule

// File: tb/tb_axi_burst_dmaster.sv
// tb_axi_burst_dmaster: directed scenarios with hand-computed expectations.
module tb_axi_burst_dmaster;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [1:0]  req_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_last, done, err;
    logic [31:0] rd_data;
    logic [3:0]  ARID, RID, AWID, BID, WSTRB;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
    logic        WLAST, WVALID, WREADY, BVALID, BREADY;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  ill_len  [4] = '{8'd16, 8'd2, 8'd0, 8'd1};
    logic [1:0]  ill_size [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic        ill_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 ACLK = ~ACLK;

    axi_burst_dmaster dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic send_req(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [1:0] s);
        @(negedge ACLK);
        req_write = w;
        req_addr  = a;
        req_len   = l;
        req_size  = s;
        req_valid = 1'b1;
        @(negedge ACLK);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        @(negedge ACLK);
        #1 got = {req_ready, ARVALID, AWVALID, RREADY, WVALID, BREADY, done, err, rd_valid, wr_ready};
        n_vec++;
        if (got !== 10'b1000000000) begin
            n_err++;
            $display("FAIL reset_held got %b exp %b", got, 10'b1000000000);
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1 got = {req_ready, ARVALID, AWVALID, RREADY, WVALID, BREADY, done, err, rd_valid, wr_ready};
        n_vec++;
        if (got !== 10'b1000000000) begin
            n_err++;
            $display("FAIL reset_released got %b exp %b", got, 10'b1000000000);
        end
    endtask

    task automatic test_single_read();
        logic [50:0] got_a, exp_a;
        logic [37:0] got_r, exp_r;
        logic [2:0]  got_i;
        send_req(1'b0, 32'h1000_0004, 8'd0, 2'd2);
        #1 got_a = {ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, AWVALID};
        exp_a = {1'b1, 4'd0, 32'h1000_0004, 8'd0, 3'd2, 2'b01, 1'b0};
        n_vec++;
        if (got_a !== exp_a) begin
            n_err++;
            $display("FAIL single_read_ar got %h exp %h", got_a, exp_a);
        end
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'hDEAD_BEEF; RLAST = 1'b1; RRESP = 2'b00; RID = 4'd0;
        #1 got_r = {ARVALID, RREADY, rd_valid, rd_data, rd_last, done, err};
        exp_r = {1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
        n_vec++;
        if (got_r !== exp_r) begin
            n_err++;
            $display("FAIL single_read_beat got %h exp %h", got_r, exp_r);
        end
        @(negedge ACLK);
        RVALID = 1'b0; RLAST = 1'b0;
        #1 got_i = {req_ready, done, RREADY};
        n_vec++;
        if (got_i !== 3'b100) begin
            n_err++;
            $display("FAIL single_read_idle got %b exp %b", got_i, 3'b100);
        end
    endtask

    task automatic test_burst_read();
        logic [35:0] got, exp;
        logic [1:0]  gap;
        int          nrd;
        for (int run = 0; run < 2; run++) begin
            send_req(1'b0, 32'h2000_0000, 8'd7, 2'd2);
            #1 n_vec++;
            if ({ARVALID, ARLEN} !== {1'b1, 8'd7}) begin
                n_err++;
                $display("FAIL burst_read_arlen got %b/%0d exp 1/7", ARVALID, ARLEN);
            end
            ARREADY = 1'b1;
            @(negedge ACLK);
            ARREADY = 1'b0;
            nrd = 0;
            for (int b = 0; b < 8; b++) begin
                if (b % 3 == 1) begin
                    RVALID = 1'b0;
                    #1 gap = {rd_valid, done};
                    n_vec++;
                    if (gap !== 2'b00) begin
                        n_err++;
                        $display("FAIL burst_read_gap run %0d beat %0d got %b exp 00", run, b, gap);
                    end
                    @(negedge ACLK);
                end
                RVALID = 1'b1;
                RDATA  = 32'hA000_0000 + 32'(b);
                RLAST  = run == 0 ? b == 7 : b == 4;
                #1 got = {rd_valid, rd_data, rd_last, done, err};
                exp = {1'b1, 32'hA000_0000 + 32'(b), b == 7, b == 7, run == 1 && b == 7};
                if (rd_valid) nrd++;
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL burst_read_beat run %0d beat %0d got %h exp %h", run, b, got, exp);
                end
                @(negedge ACLK);
            end
            RVALID = 1'b0; RLAST = 1'b0;
            #1 n_vec++;
            if (nrd !== 8 || req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL burst_read_count run %0d got %0d beats ready %b exp 8 beats ready 1", run, nrd, req_ready);
            end
        end
    endtask

    task automatic test_single_write(input logic [31:0] a, input logic [1:0] s, input logic [3:0] sin,
                                     input logic [3:0] exp_strb, input logic [1:0] bresp,
                                     input logic [3:0] bid, input logic exp_err);
        logic [50:0] got_a, exp_a;
        logic [39:0] got_w, exp_w;
        logic [3:0]  got_b, exp_b;
        send_req(1'b1, a, 8'd0, s);
        #1 got_a = {AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, ARVALID};
        exp_a = {1'b1, 4'd0, a, 8'd0, {1'b0, s}, 2'b01, 1'b0};
        n_vec++;
        if (got_a !== exp_a) begin
            n_err++;
            $display("FAIL write_aw addr %h got %h exp %h", a, got_a, exp_a);
        end
        AWREADY = 1'b1;
        @(negedge ACLK);
        AWREADY = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h5A5A_0000 ^ a; wr_strb = sin; WREADY = 1'b1;
        #1 got_w = {WVALID, wr_ready, WDATA, WSTRB, WLAST, AWVALID};
        exp_w = {1'b1, 1'b1, 32'h5A5A_0000 ^ a, exp_strb, 1'b1, 1'b0};
        n_vec++;
        if (got_w !== exp_w) begin
            n_err++;
            $display("FAIL write_w addr %h got %h exp %h", a, got_w, exp_w);
        end
        @(negedge ACLK);
        wr_valid = 1'b0; WREADY = 1'b0;
        BVALID = 1'b1; BRESP = bresp; BID = bid;
        #1 got_b = {WVALID, BREADY, done, err};
        exp_b = {1'b0, 1'b1, 1'b1, exp_err};
        n_vec++;
        if (got_b !== exp_b) begin
            n_err++;
            $display("FAIL write_b addr %h got %b exp %b", a, got_b, exp_b);
        end
        @(negedge ACLK);
        BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0;
        #1 n_vec++;
        if ({done, req_ready, BREADY} !== 3'b010) begin
            n_err++;
            $display("FAIL write_idle addr %h got %b exp 010", a, {done, req_ready, BREADY});
        end
    endtask

    task automatic test_burst_write();
        logic [8:0]  wv_pat = 9'b110111101;
        logic [8:0]  wr_pat = 9'b110100011;
        logic [38:0] got, exp;
        logic [3:0]  strb;
        int          beat = 0;
        int          hs = 0;
        send_req(1'b1, 32'h3000_0000, 8'd3, 2'd2);
        #1 n_vec++;
        if ({AWVALID, AWLEN, AWADDR} !== {1'b1, 8'd3, 32'h3000_0000}) begin
            n_err++;
            $display("FAIL burst_write_aw got %b/%0d/%h exp 1/3/30000000", AWVALID, AWLEN, AWADDR);
        end
        AWREADY = 1'b1;
        @(negedge ACLK);
        AWREADY = 1'b0;
        for (int c = 0; c < 9; c++) begin
            strb = 4'b0001 << beat;
            wr_valid = wv_pat[c]; WREADY = wr_pat[c];
            wr_data = 32'hC0DE_0000 + 32'(beat); wr_strb = strb;
            #1 got = {WVALID, wr_ready, WLAST, WDATA, WSTRB};
            exp = {wv_pat[c], wr_pat[c], beat == 3, 32'hC0DE_0000 + 32'(beat), strb};
            if (WVALID && wr_ready) hs++;
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL burst_write_cycle %0d got %h exp %h", c, got, exp);
            end
            if (wv_pat[c] && wr_pat[c]) beat++;
            @(negedge ACLK);
        end
        wr_valid = 1'b0; WREADY = 1'b0;
        #1 n_vec++;
        if (hs !== 4 || {BREADY, done, WVALID} !== 3'b100) begin
            n_err++;
            $display("FAIL burst_write_hs got %0d hs state %b exp 4 hs state 100", hs, {BREADY, done, WVALID});
        end
        @(negedge ACLK);
        BVALID = 1'b1; BRESP = 2'b00; BID = 4'd0;
        #1 n_vec++;
        if ({done, err} !== 2'b10) begin
            n_err++;
            $display("FAIL burst_write_done got %b exp 10", {done, err});
        end
        @(negedge ACLK);
        BVALID = 1'b0;
    endtask

    task automatic test_illegal();
        logic [4:0] got;
        for (int i = 0; i < 4; i++) begin
            send_req(ill_wr[i], 32'h5000_0000, ill_len[i], ill_size[i]);
            #1 got = {done, err, ARVALID, AWVALID, req_ready};
            n_vec++;
            if (got !== 5'b11001) begin
                n_err++;
                $display("FAIL illegal_resp %0d got %b exp 11001", i, got);
            end
            @(negedge ACLK);
            #1 got = {done, err, ARVALID, AWVALID, req_ready};
            n_vec++;
            if (got !== 5'b00001) begin
                n_err++;
                $display("FAIL illegal_after %0d got %b exp 00001", i, got);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [43:0] got, exp;
        send_req(1'b0, 32'h4000_0000, 8'd7, 2'd2);
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1; RDATA = 32'hB000_0000 + 32'(b); RLAST = 1'b0;
            @(negedge ACLK);
        end
        RDATA = 32'hB000_0002; wr_valid = 1'b1;
        #1 n_vec++;
        if (rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_beat3 got %b exp 1", rd_valid);
        end
        #1 ARESETn = 1'b0;
        #1 got = {ARVALID, AWVALID, RREADY, WVALID, BREADY, rd_valid, rd_last, rd_data, done, err, wr_ready, req_ready};
        exp = {43'd0, 1'b1};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_mid_async got %h exp %h", got, exp);
        end
        @(negedge ACLK);
        RVALID = 1'b0; wr_valid = 1'b0;
        ARESETn = 1'b1;
        #1 n_vec++;
        if ({req_ready, RREADY, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_mid_release got %b exp 100", {req_ready, RREADY, done});
        end
        test_single_read();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
        test_reset();
        test_single_read();
        test_burst_read();
        test_single_write(32'h2000_0003, 2'd0, 4'b1111, 4'b1000, 2'b10, 4'd0, 1'b1);
        test_single_write(32'h2000_0001, 2'd0, 4'b0000, 4'b0010, 2'b00, 4'd0, 1'b0);
        test_single_write(32'h2000_0002, 2'd1, 4'b1111, 4'b1100, 2'b00, 4'd0, 1'b0);
        test_single_write(32'h2000_0000, 2'd1, 4'b1111, 4'b0011, 2'b00, 4'd0, 1'b0);
        test_single_write(32'h2000_0008, 2'd2, 4'b0101, 4'b0101, 2'b00, 4'd0, 1'b0);
        test_single_write(32'h2000_000C, 2'd2, 4'b1111, 4'b1111, 2'b00, 4'd3, 1'b1);
        test_burst_write();
        test_illegal();
        test_reset_mid();
        @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
